// File: rtl/clock_gate_pkg.sv
// Shared types and constants for the clock gating controller.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    CG_OFF,
    CG_WAKE,
    CG_ON,
    CG_HOLD
  } cg_state_t;

  localparam int unsigned CG_STATS_W = 32;

  // Width of a down-counter that must hold max(wake, idle); never narrower than 1 bit.
  function automatic int unsigned cg_cnt_w(input int unsigned wake, input int unsigned idle);
    int unsigned m;
    m = (wake > idle) ? wake : idle;
    if (m == 0) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clock_gate_ctrl_icg_cell.sv
// Integrated clock gate: low-transparent latch on the enable followed by an AND with the clock.
module icg_cell (
  input  logic clk_in,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic r_en_lat;

  // Enable only changes while clk_in is low, so gclk can never be chopped mid-pulse.
  always_latch begin
    if (!clk_in) r_en_lat <= en | test_en;
  end

  assign gclk = clk_in & r_en_lat;

endmodule

// File: rtl/clock_gate_ctrl.sv
// N-channel clock gating controller with req/ack handshake, wake-up delay and idle hysteresis.
// Optional per-channel active-cycle counters when CLOCK_GATE_CTRL_STATS_EN is defined.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 8
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         scan_en,
  input  logic [N-1:0] clk_req,
  output logic [N-1:0] clk_ack,
  output logic [N-1:0] gclk_out,
  output logic [N-1:0] gate_en
`ifdef CLOCK_GATE_CTRL_STATS_EN
  ,
  output logic [N*CG_STATS_W-1:0] active_cnt
`endif
);

  localparam int unsigned CNT_W = cg_cnt_w(WAKE_CYC, IDLE_CYC);
  localparam int unsigned WAKE_LD_I = (WAKE_CYC > 0) ? WAKE_CYC - 1 : 0;
  localparam int unsigned IDLE_LD_I = (IDLE_CYC > 0) ? IDLE_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_LD_I);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_LD_I);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    cg_state_t        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;

    // Next-state and counter logic for one channel.
    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
        CG_OFF: begin
          if (clk_req[g]) begin
            if (WAKE_CYC > 0) begin
              w_state_d = CG_WAKE;
              w_cnt_d   = WAKE_LD;
            end else begin
              w_state_d = CG_ON;
            end
          end
        end
        // A dropped request does not abort the wake; ON re-evaluates it afterwards.
        CG_WAKE: begin
          if (r_cnt == '0) w_state_d = CG_ON;
          else             w_cnt_d   = r_cnt - CNT_ONE;
        end
        CG_ON: begin
          if (!clk_req[g]) begin
            if (IDLE_CYC > 0) begin
              w_state_d = CG_HOLD;
              w_cnt_d   = IDLE_LD;
            end else begin
              w_state_d = CG_OFF;
            end
          end
        end
        // A request, even on the expiry cycle, wins over gating off.
        CG_HOLD: begin
          if (clk_req[g]) begin
            w_state_d = CG_ON;
            w_cnt_d   = '0;
          end else if (r_cnt == '0) begin
            w_state_d = CG_OFF;
          end else begin
            w_cnt_d = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_d = CG_OFF;
          w_cnt_d   = '0;
        end
      endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_state <= CG_OFF;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
      end
    end

    assign gate_en[g] = (r_state != CG_OFF);
    assign clk_ack[g] = (r_state == CG_ON) || (r_state == CG_HOLD);

    icg_cell u_icg (
      .clk_in  (clk_in),
      .en      (gate_en[g]),
      .test_en (scan_en),
      .gclk    (gclk_out[g])
    );

`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic [CG_STATS_W-1:0] r_active;

    // Saturating count of cycles with the gate enabled.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_active <= '0;
      end else if (gate_en[g] && (r_active != '1)) begin
        r_active <= r_active + CG_STATS_W'(1);
      end
    end

    assign active_cnt[g*CG_STATS_W +: CG_STATS_W] = r_active;
`endif
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed self-checking bench: instance A uses WAKE_CYC=2/IDLE_CYC=4, instance B uses 0/0.
module tb_clock_gate_ctrl;

  logic       clk_in;
  logic       rst;
  logic       scan_en;
  logic [3:0] clk_req;
  logic [3:0] a_ack, a_gclk, a_gate;
  logic [3:0] b_ack, b_gclk, b_gate;
`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [127:0] a_cnt, b_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  clock_gate_ctrl #(.N(4), .WAKE_CYC(2), .IDLE_CYC(4)) u_dut_a (
    .clk_in   (clk_in),
    .rst      (rst),
    .scan_en  (scan_en),
    .clk_req  (clk_req),
    .clk_ack  (a_ack),
    .gclk_out (a_gclk),
    .gate_en  (a_gate)
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,
    .active_cnt (a_cnt)
`endif
  );

  clock_gate_ctrl #(.N(4), .WAKE_CYC(0), .IDLE_CYC(0)) u_dut_b (
    .clk_in   (clk_in),
    .rst      (rst),
    .scan_en  (scan_en),
    .clk_req  (clk_req),
    .clk_ack  (b_ack),
    .gclk_out (b_gclk),
    .gate_en  (b_gate)
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,
    .active_cnt (b_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one rising edge, then settle 1 ns into the high phase.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    scan_en = 1'b0;
    clk_req = 4'b0000;
    step();
    step();
    chk("reset_gate_a", 32'(a_gate), 32'h0);
    chk("reset_ack_a",  32'(a_ack),  32'h0);
    chk("reset_gclk_a", 32'(a_gclk), 32'h0);
    chk("reset_ack_b",  32'(b_ack),  32'h0);

    rst = 1'b0;
    step();

    // Wake on channel 0.
    clk_req = 4'b0001;
    step();                                   // edge 1: req sampled
    chk("wake_e1_gate_a", 32'(a_gate), 32'h1);
    chk("wake_e1_ack_a",  32'(a_ack),  32'h0);
    chk("wake_e1_gclk_a", 32'(a_gclk), 32'h0);
    chk("zero_e1_ack_b",  32'(b_ack),  32'h1);
    step();                                   // edge 2
    chk("wake_e2_ack_a",  32'(a_ack),  32'h0);
    chk("wake_e2_gclk_a", 32'(a_gclk), 32'h1);
    step();                                   // edge 3
    chk("wake_e3_ack_a",  32'(a_ack),  32'h1);

    // Idle timeout on channel 0.
    clk_req = 4'b0000;
    step();                                   // h1
    chk("idle_h1_ack_a",  32'(a_ack),  32'h1);
    chk("zero_down_ack_b", 32'(b_ack), 32'h0);
    chk("zero_down_gate_b", 32'(b_gate), 32'h0);
    step();
    step();
    step();                                   // h4
    chk("idle_h4_ack_a",  32'(a_ack),  32'h1);
    chk("idle_h4_gate_a", 32'(a_gate), 32'h1);
    step();                                   // h5
    chk("idle_h5_ack_a",  32'(a_ack),  32'h0);
    chk("idle_h5_gate_a", 32'(a_gate), 32'h0);
    chk("idle_h5_lastpulse_a", 32'(a_gclk), 32'h1);
    step();
    chk("idle_h6_gclk_a", 32'(a_gclk), 32'h0);

    // Hysteresis on channel 1.
    clk_req = 4'b0010;
    step();
    step();
    step();
    chk("hyst_up_ack_a", 32'(a_ack[1]), 32'h1);
    clk_req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hyst_drop_ack_a", 32'(a_ack[1]), 32'h1);
    end
    clk_req = 4'b0010;
    step();                                   // back to ON
    chk("hyst_back_ack_a", 32'(a_ack[1]), 32'h1);
    clk_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();                                 // HOLD cnt 3..0
    end
    chk("hyst_cnt0_ack_a", 32'(a_ack[1]), 32'h1);
    clk_req = 4'b0010;
    step();                                   // expiry cycle with req=1
    chk("hyst_expiry_ack_a", 32'(a_ack[1]), 32'h1);
    step();
    chk("hyst_stay_ack_a", 32'(a_ack[1]), 32'h1);

    // Let channel 1 gate off, then pulse channel 2 for one cycle.
    clk_req = 4'b0000;
    for (int i = 0; i < 6; i++) step();
    chk("ch1_off_gate_a", 32'(a_gate), 32'h0);
    clk_req = 4'b0100;
    step();                                   // edge 1: WAKE
    clk_req = 4'b0000;
    step();                                   // edge 2
    chk("abort_e2_ack_a",  32'(a_ack[2]),  32'h0);
    chk("abort_e2_gate_a", 32'(a_gate[2]), 32'h1);
    step();                                   // edge 3: ON
    chk("abort_e3_ack_a",  32'(a_ack[2]),  32'h1);
    for (int i = 0; i < 4; i++) step();       // edges 4..7: HOLD
    chk("abort_e7_ack_a",  32'(a_ack[2]),  32'h1);
    step();                                   // edge 8: OFF
    chk("abort_e8_ack_a",  32'(a_ack[2]),  32'h0);
    chk("abort_e8_gate_a", 32'(a_gate[2]), 32'h0);

    // Scan bypass.
    scan_en = 1'b1;
    step();
    step();
    chk("scan_gclk_a", 32'(a_gclk), 32'hF);
    chk("scan_gclk_b", 32'(b_gclk), 32'hF);
    chk("scan_ack_a",  32'(a_ack),  32'h0);
    chk("scan_gate_a", 32'(a_gate), 32'h0);
    scan_en = 1'b0;
    step();
    step();
    chk("noscan_gclk_a", 32'(a_gclk), 32'h0);

    // Reset while channel 3 is ON.
    clk_req = 4'b1000;
    step();
    step();
    step();
    chk("rst_pre_ack_a", 32'(a_ack), 32'h8);
    chk("rst_pre_ack_b", 32'(b_ack), 32'h8);
    rst = 1'b1;
    step();
    chk("rst_mid_ack_a",  32'(a_ack),  32'h0);
    chk("rst_mid_gate_a", 32'(a_gate), 32'h0);
    chk("rst_mid_ack_b",  32'(b_ack),  32'h0);
`ifdef CLOCK_GATE_CTRL_STATS_EN
    chk("stats_rst_b", b_cnt[3*32 +: 32], 32'h0);
`endif
    rst = 1'b0;
    step();                                   // edge 1 after release
    chk("rst_rel_ack_b",  32'(b_ack),  32'h8);
    chk("rst_rel_gate_a", 32'(a_gate), 32'h8);
    step();
    step();                                   // edge 3 after release
    chk("rst_rel_ack_a", 32'(a_ack), 32'h8);
`ifdef CLOCK_GATE_CTRL_STATS_EN
    chk("stats_cnt_b3", b_cnt[3*32 +: 32], 32'd2);
    chk("stats_cnt_a3", a_cnt[3*32 +: 32], 32'd2);
    chk("stats_cnt_b0", b_cnt[0 +: 32],    32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
